// File: rtl/cpu_params_pkg.sv
// Shared CPU sizing: FP register count, FP data width and register address width.
package cpu_params_pkg;
    localparam int MAX_FPR = 32;
    localparam int FLEN    = 32;
    localparam int FPR_ASZ = 5;
endpackage

// File: rtl/fp_wb_arb.sv
// FP register-file write arbiter: loads win and write at N+1; FPU results queue and write no earlier than N+2.
// fpu_ready drops when the FIFO is full; FP_WB_SCOREBOARD_EN adds per-register pending bits.
module fp_wb_arb
    import cpu_params_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               ld_valid,
    input  logic [FPR_ASZ-1:0] ld_addr,
    input  logic [FLEN-1:0]    ld_data,
    input  logic               fpu_valid,
    output logic               fpu_ready,
    input  logic [FPR_ASZ-1:0] fpu_addr,
    input  logic [FLEN-1:0]    fpu_data,
    input  logic               iss_valid,
    input  logic [FPR_ASZ-1:0] iss_addr,
    output logic               fpr_Fd_wr,
    output logic [FPR_ASZ-1:0] fpr_Fd_addr,
    output logic [FLEN-1:0]    fpr_Fd_data,
    output logic [MAX_FPR-1:0] fpr_pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [FPR_ASZ-1:0] mem_addr [FIFO_DEPTH];
    logic [FLEN-1:0]    mem_data [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               push;
    logic               pop;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign fpu_ready = (count < CW'(FIFO_DEPTH));
    assign push      = fpu_valid & fpu_ready;
    assign pop       = !ld_valid && (count != '0);

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_addr[wr_ptr] <= fpu_addr;
            mem_data[wr_ptr] <= fpu_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            fpr_Fd_wr   <= 1'b0;
            fpr_Fd_addr <= '0;
            fpr_Fd_data <= '0;
        end else begin
            fpr_Fd_wr <= ld_valid | pop;
            if (ld_valid) begin
                fpr_Fd_addr <= ld_addr;
                fpr_Fd_data <= ld_data;
            end else if (pop) begin
                fpr_Fd_addr <= mem_addr[rd_ptr];
                fpr_Fd_data <= mem_data[rd_ptr];
            end
        end
    end

`ifdef FP_WB_SCOREBOARD_EN
    logic [MAX_FPR-1:0] pending_nxt;

    // Set is applied after clear so a re-issue in the clearing cycle keeps the bit.
    always_comb begin
        pending_nxt = fpr_pending;
        if (fpr_Fd_wr) begin
            pending_nxt[fpr_Fd_addr] = 1'b0;
        end
        if (iss_valid) begin
            pending_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            fpr_pending <= '0;
        end else begin
            fpr_pending <= pending_nxt;
        end
    end
`else
    logic unused_iss;

    assign unused_iss  = ^{iss_valid, iss_addr};
    assign fpr_pending = '0;
`endif

endmodule

// File: doc/fp_wb_arb.md
FP_WB_ARB -- requirements
Module: fp_wb_arb

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, FPU result FIFO entries; power of two, 2..16.
REQ-002 Parameters MAX_FPR, FLEN and FPR_ASZ SHALL be taken from cpu_params_pkg.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 ld_valid  input  1  FP load (FLW) result valid; no backpressure, always accepted.
REQ-006 ld_addr  input  FPR_ASZ  load destination Fd.
REQ-007 ld_data  input  FLEN  load result.
REQ-008 fpu_valid  input  1  FPU result valid.
REQ-009 fpu_ready  output  1  FIFO can accept an FPU result.
REQ-010 fpu_addr  input  FPR_ASZ  FPU destination Fd.
REQ-011 fpu_data  input  FLEN  FPU result.
REQ-012 iss_valid  input  1  an FP-writing instruction issued.
REQ-013 iss_addr  input  FPR_ASZ  Fd of the issued instruction.
REQ-014 fpr_Fd_wr  output  1  FP register file write strobe (registered).
REQ-015 fpr_Fd_addr  output  FPR_ASZ  register file write address (registered).
REQ-016 fpr_Fd_data  output  FLEN  register file write data (registered).
REQ-017 fpr_pending  output  MAX_FPR  per-register outstanding-write bits.

Function
REQ-018 fpu_ready SHALL equal (count < FIFO_DEPTH), where count is the registered occupancy, independent of a same-cycle pop.
REQ-019 An FPU result SHALL be pushed at the edge where fpu_valid & fpu_ready; fpu_valid with fpu_ready low SHALL leave the FIFO unchanged, and the source holds its data.
REQ-020 Arbitration each cycle: ld_valid wins; otherwise, if count > 0, the FIFO head is popped; otherwise there is no write.
REQ-021 Load latency: ld_valid in cycle N SHALL produce fpr_Fd_wr=1 with ld_addr/ld_data in cycle N+1.
REQ-022 FPU latency: a result accepted in cycle N SHALL be eligible for pop no earlier than cycle N+1, so fpr_Fd_wr is asserted no earlier than N+2.
REQ-023 The FIFO SHALL deliver results in acceptance order; pointers wrap modulo FIFO_DEPTH.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-025 When fpr_Fd_wr=0, fpr_Fd_addr and fpr_Fd_data SHALL hold their previous values.
REQ-026 Continuous ld_valid SHALL starve the FIFO; once the FIFO is full, fpu_ready stays 0 until a pop.

Reset
REQ-027 While reset_in=1 at an edge: FIFO empty (count=0, pointers=0), fpr_Fd_wr=0, fpr_Fd_addr=0, fpr_Fd_data=0, fpr_pending=0.
REQ-028 fpu_ready SHALL read 1 in the first cycle after reset.
REQ-029 Reset asserted mid-operation SHALL discard all queued results with no fpr_Fd_wr pulse; ld_valid and fpu_valid in the reset cycle are ignored.

Configuration
REQ-030 Macro FP_WB_SCOREBOARD_EN defined: iss_valid sets fpr_pending[iss_addr] at the next edge; a registered write (fpr_Fd_wr=1) clears fpr_pending[fpr_Fd_addr] at the next edge; simultaneous set and clear of the same index results in set.
REQ-031 Macro FP_WB_SCOREBOARD_EN undefined: fpr_pending is tied to 0, iss_valid and iss_addr are ignored, and port list and write-path behaviour are unchanged.

Verification
REQ-032 Reset, then ld_valid=1, ld_addr=5, ld_data=32'h3F800000 for one cycle -> next cycle fpr_Fd_wr=1, addr=5, data=32'h3F800000; the following cycle fpr_Fd_wr=0.
REQ-033 Push FPU results to F1, F2, F3 with ld_valid held 1 -> no FPU writes while loads continue; after ld_valid drops, writes occur to F1, F2, F3 on three consecutive cycles.
REQ-034 Hold ld_valid=1 and push 4 FPU results -> fpu_ready=0 after the 4th; a 5th fpu_valid is not accepted until one cycle after ld_valid drops.
REQ-035 Same cycle: ld_valid to F7 and FPU push to F8, FIFO empty -> F7 written at N+1, F8 written at N+2.
REQ-036 Fill FIFO with 3 entries, assert reset_in one cycle -> no fpr_Fd_wr afterwards, fpu_ready=1, fpr_pending=0.
REQ-037 With FP_WB_SCOREBOARD_EN: iss_valid to F9 -> fpr_pending[9]=1; a load to F9 -> bit clears the cycle after fpr_Fd_wr; iss_valid to F9 in the clearing cycle -> bit stays 1.
